// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for the ALU/LSU/MUL/BR writeback ports.
// Each FU result is parked in a 1-entry slot. A round-robin search starting at rr_ptr
// picks one occupied slot per cycle and broadcasts it on the registered CDB outputs.
// Optional build macro CDB_ARB_PERF_EN adds per-FU grant counters and a stall counter.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      cdb_en_o,
  output logic [TAG_W-1:0]          cdb_reg_addr_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [SRC_W-1:0]          cdb_src_o
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]     perf_grant_cnt_o,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  logic [NUM_REQ-1:0]             slot_v_q, slot_v_d;
  logic [NUM_REQ-1:0][TAG_W-1:0]  slot_tag_q, slot_tag_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data_q, slot_data_d;
  logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic                           cdb_en_q, cdb_en_d;
  logic [TAG_W-1:0]               cdb_addr_q, cdb_addr_d;
  logic [DATA_W-1:0]              cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]               cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0]             grant_s;
  logic [SRC_W-1:0]               grant_idx_s;
  logic                           grant_any_s;
  logic [NUM_REQ-1:0]             req_ready_s;

  // Round-robin search over occupied slots from rr_ptr; flush suppresses any grant.
  always_comb begin
    int               sum;
    logic [SRC_W-1:0] idx;
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    sum         = 0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(rr_ptr_q) + i;
      idx = SRC_W'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
      if (!grant_any_s && slot_v_q[idx] && !flush_i) begin
        grant_any_s  = 1'b1;
        grant_s[idx] = 1'b1;
        grant_idx_s  = idx;
      end else begin
        grant_any_s  = grant_any_s;
      end
    end
  end

  // A slot can take a new result when empty or when it is draining this cycle.
  assign req_ready_s = {NUM_REQ{~flush_i}} & (~slot_v_q | grant_s);
  assign req_ready_o = req_ready_s;

  // Slot update: flush empties everything, capture refills, grant drains.
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_tag_d  = slot_tag_q;
    slot_data_d = slot_data_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (flush_i) begin
        slot_v_d[k] = 1'b0;
      end else if (req_valid_i[k] && req_ready_s[k]) begin
        slot_v_d[k]    = 1'b1;
        slot_tag_d[k]  = req_tag_i[k*TAG_W +: TAG_W];
        slot_data_d[k] = req_data_i[k*DATA_W +: DATA_W];
      end else if (grant_s[k]) begin
        slot_v_d[k] = 1'b0;
      end else begin
        slot_v_d[k] = slot_v_q[k];
      end
    end
  end

  // Broadcast and pointer update: payload and pointer hold when nothing is granted.
  always_comb begin
    cdb_en_d   = 1'b0;
    cdb_addr_d = cdb_addr_q;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_any_s) begin
      cdb_en_d   = 1'b1;
      cdb_addr_d = slot_tag_q[grant_idx_s];
      cdb_data_d = slot_data_q[grant_idx_s];
      cdb_src_d  = grant_idx_s;
      rr_ptr_d   = (grant_idx_s == SRC_W'(NUM_REQ - 1)) ? '0 : (grant_idx_s + SRC_W'(1));
    end else begin
      cdb_en_d   = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      slot_v_q    <= '0;
      slot_tag_q  <= '0;
      slot_data_q <= '0;
      rr_ptr_q    <= '0;
      cdb_en_q    <= 1'b0;
      cdb_addr_q  <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_tag_q  <= slot_tag_d;
      slot_data_q <= slot_data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_en_q    <= cdb_en_d;
      cdb_addr_q  <= cdb_addr_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_en_o       = cdb_en_q;
  assign cdb_reg_addr_o = cdb_addr_q;
  assign cdb_data_o     = cdb_data_q;
  assign cdb_src_o      = cdb_src_q;

`ifdef CDB_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_grant_q, perf_grant_d;
  logic [31:0]              perf_stall_q, perf_stall_d;

  // Counter next values: grants per FU, stalls when a valid FU is refused outside flush.
  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_stall_d = perf_stall_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_s[k]) begin
        perf_grant_d[k] = perf_grant_q[k] + 32'd1;
      end else begin
        perf_grant_d[k] = perf_grant_q[k];
      end
    end
    if (!flush_i && |(req_valid_i & ~req_ready_s)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Performance counters, only cleared by reset and wrapping naturally.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_grant_q <= '0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_grant_cnt_o = perf_grant_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus random traffic against a slot-level reference model.
module tb_cdb_arbiter;

  logic         clk_i = 1'b0;
  logic         reset_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic [3:0]   req_valid_i = 4'd0;
  logic [19:0]  req_tag_i = 20'd0;
  logic [127:0] req_data_i = 128'd0;
  logic [3:0]   req_ready_o;
  logic         cdb_en_o;
  logic [4:0]   cdb_reg_addr_o;
  logic [31:0]  cdb_data_o;
  logic [1:0]   cdb_src_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_v[4];
  logic [4:0]  m_tag[4];
  logic [31:0] m_data[4];
  int          m_rr;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_dat;
  logic [1:0]  m_src;

  cdb_arbiter dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_tag_i(req_tag_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .cdb_en_o(cdb_en_o), .cdb_reg_addr_o(cdb_reg_addr_o),
    .cdb_data_o(cdb_data_o), .cdb_src_o(cdb_src_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 1'b0; m_tag[k] = 5'd0; m_data[k] = 32'd0;
    end
    m_rr = 0; m_en = 1'b0; m_addr = 5'd0; m_dat = 32'd0; m_src = 2'd0;
  endtask

  // one clock: drive inputs, check ready before the edge, advance model, check CDB after it
  task automatic step(input logic fl, input logic [3:0] vld,
                      input logic [19:0] tg, input logic [127:0] dt);
    int g;
    int k;
    logic [3:0] rdy;
    @(negedge clk_i);
    flush_i = fl; req_valid_i = vld; req_tag_i = tg; req_data_i = dt;
    #1;
    g = -1;
    for (int off = 0; off < 4; off++) begin
      k = (m_rr + off) % 4;
      if (g < 0 && m_v[k]) g = k;
    end
    for (int j = 0; j < 4; j++) rdy[j] = !fl && (!m_v[j] || g == j);
    chk("ready", 64'(req_ready_o), 64'(rdy));
    @(posedge clk_i);
    if (fl) begin
      for (int j = 0; j < 4; j++) m_v[j] = 1'b0;
      m_en = 1'b0;
    end else begin
      if (g >= 0) begin
        m_en = 1'b1; m_addr = m_tag[g]; m_dat = m_data[g]; m_src = 2'(g);
        m_rr = (g + 1) % 4;
        m_v[g] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
      for (int j = 0; j < 4; j++) begin
        if (vld[j] && rdy[j]) begin
          m_v[j] = 1'b1; m_tag[j] = tg[j*5 +: 5]; m_data[j] = dt[j*32 +: 32];
        end
      end
    end
    #1;
    chk("cdb_en", 64'(cdb_en_o), 64'(m_en));
    chk("cdb_addr", 64'(cdb_reg_addr_o), 64'(m_addr));
    chk("cdb_data", 64'(cdb_data_o), 64'(m_dat));
    chk("cdb_src", 64'(cdb_src_o), 64'(m_src));
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 20'd0, 128'd0);
  endtask

  // async reset applied between edges, output must clear at once
  task automatic do_reset();
    @(negedge clk_i);
    flush_i = 1'b0; req_valid_i = 4'd0;
    #2;
    reset_ni = 1'b0;
    #1;
    chk("rst_en_async", 64'(cdb_en_o), 64'd0);
    chk("rst_addr_async", 64'(cdb_reg_addr_o), 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    model_reset();
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'hF);
    chk("rst_en", 64'(cdb_en_o), 64'd0);
    chk("rst_src", 64'(cdb_src_o), 64'd0);
  endtask

  initial begin
    logic [19:0]  rt;
    logic [127:0] rd;
    logic [3:0]   rv;
    model_reset();
    reset_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("por_en", 64'(cdb_en_o), 64'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    chk("por_ready", 64'(req_ready_o), 64'hF);

    // single ALU result
    step(1'b0, 4'b0001, {15'd0, 5'd7}, {96'd0, 32'hDEAD_BEEF});
    chk("single_lat0", 64'(cdb_en_o), 64'd0);
    idle();
    chk("single_en", 64'(cdb_en_o), 64'd1);
    chk("single_addr", 64'(cdb_reg_addr_o), 64'd7);
    chk("single_data", 64'(cdb_data_o), 64'hDEAD_BEEF);
    chk("single_src", 64'(cdb_src_o), 64'd0);
    idle();
    chk("single_off", 64'(cdb_en_o), 64'd0);

    // contention from rr_ptr=0
    do_reset();
    step(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
         {32'h4444, 32'h3333, 32'h2222, 32'h1111});
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("cont_src", 64'(cdb_src_o), 64'(i));
      chk("cont_tag", 64'(cdb_reg_addr_o), 64'(i + 1));
    end
    idle();
    chk("cont_done", 64'(cdb_en_o), 64'd0);

    // pointer after a MUL grant is 3: ALU wins over MUL, then MUL
    step(1'b0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, 128'd0);
    idle();
    step(1'b0, 4'b0101, {5'd0, 5'd21, 5'd0, 5'd20}, {32'd0, 32'hAA, 32'd0, 32'h55});
    idle();
    chk("rr_first", 64'(cdb_src_o), 64'd0);
    idle();
    chk("rr_second", 64'(cdb_src_o), 64'd2);
    chk("rr_second_tag", 64'(cdb_reg_addr_o), 64'd21);

    // MUL back-to-back
    step(1'b0, 4'b0100, {5'd0, 5'd10, 10'd0}, 128'd0);
    step(1'b0, 4'b0100, {5'd0, 5'd11, 10'd0}, 128'd0);
    chk("b2b_t10", 64'(cdb_reg_addr_o), 64'd10);
    step(1'b0, 4'b0100, {5'd0, 5'd12, 10'd0}, 128'd0);
    chk("b2b_t11", 64'(cdb_reg_addr_o), 64'd11);
    idle();
    chk("b2b_t12", 64'(cdb_reg_addr_o), 64'd12);
    chk("b2b_en", 64'(cdb_en_o), 64'd1);
    idle();

    // flush with three slots full
    step(1'b0, 4'b0111, {5'd0, 5'd30, 5'd29, 5'd28}, 128'd0);
    step(1'b1, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, 128'd0);
    chk("flush_en", 64'(cdb_en_o), 64'd0);
    idle();
    chk("flush_stale", 64'(cdb_en_o), 64'd0);
    chk("flush_ready", 64'(req_ready_o), 64'hF);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rv = 4'($urandom_range(0, 15));
      rt = 20'($urandom);
      rd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, rv, rt, rd);
    end
    do_reset();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
